// File: rtl/dds_pkg.sv
// Shared types and constants for the multi-channel sine/cosine DDS.
//   cfg_sel_e : configuration field selector (FTW, PHASE_OFS, AMP_SIN, AMP_COS)
//   state_e   : frame sequencer states
//   PIPE_DEPTH: stages between channel issue and result (S0 phase, S1 ROM, S2 multiply)
package dds_pkg;
    typedef enum logic [1:0] {
        FTW       = 2'd0,
        PHASE_OFS = 2'd1,
        AMP_SIN   = 2'd2,
        AMP_COS   = 2'd3
    } cfg_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int PIPE_DEPTH = 3;
endpackage

// File: rtl/dds_lut_rom.sv
// Full-period sine table with two registered read ports (sine and cosine
// lookups share one table).
//   i_clk              : clock, rising edge
//   i_addr_a, i_addr_b : read addresses
//   o_data_a, o_data_b : signed Q1.(LUT_W-1) samples, one cycle after address
// The table is generated in place as
// round((2^(LUT_W-1)-1) * sin(2*pi*a/2^ADDR_W)).
module dds_lut_rom #(
    parameter int    ADDR_W   = 8,
    parameter int    LUT_W    = 8,
    parameter string LUT_FILE = "sine_lut.txt"
) (
    input  logic                    i_clk,
    input  logic [ADDR_W-1:0]       i_addr_a,
    input  logic [ADDR_W-1:0]       i_addr_b,
    output logic signed [LUT_W-1:0] o_data_a,
    output logic signed [LUT_W-1:0] o_data_b
);
    logic signed [LUT_W-1:0] r_mem [2**ADDR_W];

    initial begin : init_rom
        real v;
        int  q;
        for (int a = 0; a < 2**ADDR_W; a++) begin
            v = (2.0**(LUT_W-1) - 1.0) *
                $sin(2.0 * 3.14159265358979 * a / (2.0**ADDR_W));
            q = (v < 0.0) ? -$rtoi(-v + 0.5) : $rtoi(v + 0.5);
            r_mem[a] = LUT_W'(q);
        end
    end

    always_ff @(posedge i_clk) begin
        o_data_a <= r_mem[i_addr_a];
        o_data_b <= r_mem[i_addr_b];
    end
endmodule

// File: rtl/dds_multi_channel.sv
// Time-multiplexed N-channel sine/cosine DDS. A tick starts a frame that
// walks all channels through one shared 3-stage pipeline; results stream out
// one channel per cycle.
//   clk, rst          : clock; synchronous active-low reset
//   tick_i, sync_i    : frame start; zero all accumulators for that frame
//   ch_en_i           : per-channel enable, latched at the accepted tick
//   cfg_we_i/ch/sel/data : shadow config write (FTW, PHASE_OFS, AMP_SIN, AMP_COS)
//   out_valid_o, out_ch_o, sine_o, cosine_o : per-channel result stream
//   busy_o, frame_done_o, overrun_o         : frame status
module dds_multi_channel
    import dds_pkg::*;
#(
    parameter int    N_CH     = 4,
    parameter int    PHASE_W  = 16,
    parameter int    ADDR_W   = 8,
    parameter int    LUT_W    = 8,
    parameter int    AMP_W    = 8,
    parameter int    AMP_QI   = 3,
    parameter string LUT_FILE = "sine_lut.txt",
    localparam int   CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int   OUT_W    = AMP_W + LUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_i,
    input  logic                    sync_i,
    input  logic [N_CH-1:0]         ch_en_i,
    input  logic                    cfg_we_i,
    input  logic [CH_W-1:0]         cfg_ch_i,
    input  logic [1:0]              cfg_sel_i,
    input  logic [PHASE_W-1:0]      cfg_data_i,
    output logic                    out_valid_o,
    output logic [CH_W-1:0]         out_ch_o,
    output logic signed [OUT_W-1:0] sine_o,
    output logic signed [OUT_W-1:0] cosine_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    overrun_o
);
    // Quarter period offset turns the sine address into the cosine address.
    localparam logic [ADDR_W-1:0] QUARTER = {2'b01, {(ADDR_W-2){1'b0}}};

    logic [N_CH-1:0][PHASE_W-1:0] r_ftw_sh, r_ofs_sh, r_ftw, r_ofs, r_acc;
    logic [N_CH-1:0][AMP_W-1:0]   r_asin_sh, r_acos_sh, r_asin, r_acos;
    logic [N_CH-1:0][PHASE_W-1:0] w_ftw_nx, w_ofs_nx;
    logic [N_CH-1:0][AMP_W-1:0]   w_asin_nx, w_acos_nx;

    state_e                  r_state;
    logic [CH_W-1:0]         r_cnt, r_ch_s0, r_ch_s1;
    logic [N_CH-1:0]         r_en;
    logic                    r_sync;
    logic [PIPE_DEPTH-1:0]   r_vld, r_last;
    logic [ADDR_W-1:0]       r_sin_addr, r_cos_addr;
    logic signed [LUT_W-1:0] w_lut_sin, w_lut_cos;

    logic                    w_issue, w_last_issue;
    logic [PHASE_W-1:0]      w_pbase, w_phase;
    logic [ADDR_W-1:0]       w_addr;
    logic signed [OUT_W-1:0] w_amp_s, w_amp_c, w_lut_s, w_lut_c, w_prod_s, w_prod_c;

    // Shadow with this cycle's write applied, so a write coinciding with
    // the accepted tick lands in the active copy of that same frame.
    always_comb begin
        w_ftw_nx  = r_ftw_sh;
        w_ofs_nx  = r_ofs_sh;
        w_asin_nx = r_asin_sh;
        w_acos_nx = r_acos_sh;
        if (cfg_we_i && (int'(cfg_ch_i) < N_CH)) begin
            case (cfg_sel_i)
                FTW:       w_ftw_nx[cfg_ch_i]  = cfg_data_i;
                PHASE_OFS: w_ofs_nx[cfg_ch_i]  = cfg_data_i;
                AMP_SIN:   w_asin_nx[cfg_ch_i] = cfg_data_i[AMP_W-1:0];
                default:   w_acos_nx[cfg_ch_i] = cfg_data_i[AMP_W-1:0];
            endcase
        end
    end

    assign w_issue      = (r_state == RUN);
    assign w_last_issue = w_issue && (int'(r_cnt) == N_CH - 1);
    assign w_pbase      = r_sync ? '0 : r_acc[r_cnt];
    assign w_phase      = w_pbase + r_ofs[r_cnt];
    assign w_addr       = w_phase[PHASE_W-1 -: ADDR_W];

    // Active amps and enables are frozen for the whole frame, so S2 can
    // index them with the channel tag instead of carrying them down the pipe.
    assign w_amp_s  = OUT_W'($signed(r_asin[r_ch_s1]));
    assign w_amp_c  = OUT_W'($signed(r_acos[r_ch_s1]));
    assign w_lut_s  = OUT_W'(w_lut_sin);
    assign w_lut_c  = OUT_W'(w_lut_cos);
    assign w_prod_s = w_amp_s * w_lut_s;
    assign w_prod_c = w_amp_c * w_lut_c;

    dds_lut_rom #(
        .ADDR_W   (ADDR_W),
        .LUT_W    (LUT_W),
        .LUT_FILE (LUT_FILE)
    ) u_rom (
        .i_clk    (clk),
        .i_addr_a (r_sin_addr),
        .i_addr_b (r_cos_addr),
        .o_data_a (w_lut_sin),
        .o_data_b (w_lut_cos)
    );

    assign out_valid_o  = r_vld[PIPE_DEPTH-1];
    assign frame_done_o = r_last[PIPE_DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ftw_sh   <= '0;
            r_ofs_sh   <= '0;
            r_asin_sh  <= '0;
            r_acos_sh  <= '0;
            r_ftw      <= '0;
            r_ofs      <= '0;
            r_asin     <= '0;
            r_acos     <= '0;
            r_acc      <= '0;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ch_s0    <= '0;
            r_ch_s1    <= '0;
            r_en       <= '0;
            r_sync     <= 1'b0;
            r_vld      <= '0;
            r_last     <= '0;
            r_sin_addr <= '0;
            r_cos_addr <= '0;
            out_ch_o   <= '0;
            sine_o     <= '0;
            cosine_o   <= '0;
            busy_o     <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            r_ftw_sh  <= w_ftw_nx;
            r_ofs_sh  <= w_ofs_nx;
            r_asin_sh <= w_asin_nx;
            r_acos_sh <= w_acos_nx;
            overrun_o <= tick_i && (r_state != IDLE);
            r_vld     <= {r_vld[PIPE_DEPTH-2:0], w_issue};
            r_last    <= {r_last[PIPE_DEPTH-2:0], w_last_issue};
            r_ch_s1   <= r_ch_s0;

            case (r_state)
                IDLE: begin
                    if (tick_i) begin
                        r_ftw   <= w_ftw_nx;
                        r_ofs   <= w_ofs_nx;
                        r_asin  <= w_asin_nx;
                        r_acos  <= w_acos_nx;
                        r_en    <= ch_en_i;
                        r_sync  <= sync_i;
                        r_cnt   <= '0;
                        busy_o  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // S0: phase, both ROM addresses and accumulator advance
                    r_sin_addr <= w_addr;
                    r_cos_addr <= w_addr + QUARTER;
                    r_ch_s0    <= r_cnt;
                    if (r_en[r_cnt])
                        r_acc[r_cnt] <= w_pbase + r_ftw[r_cnt];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_issue)
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    // frame_done_o is high now; leave once it has been seen
                    if (r_last[PIPE_DEPTH-1]) begin
                        busy_o  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // S2: outputs only move when a result lands, otherwise they hold
            if (r_vld[PIPE_DEPTH-2]) begin
                out_ch_o <= r_ch_s1;
                sine_o   <= r_en[r_ch_s1] ? w_prod_s : '0;
                cosine_o <= r_en[r_ch_s1] ? w_prod_c : '0;
            end
        end
    end
endmodule

// File: tb/tb_dds_multi_channel.sv
module tb_dds_multi_channel;
    localparam int N_CH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick_i = 1'b0, sync_i = 1'b0, cfg_we_i = 1'b0;
    logic [3:0]         ch_en_i = '0;
    logic [1:0]         cfg_ch_i = '0, cfg_sel_i = '0;
    logic [15:0]        cfg_data_i = '0;
    logic               out_valid_o, busy_o, frame_done_o, overrun_o;
    logic [1:0]         out_ch_o;
    logic signed [15:0] sine_o, cosine_o;

    always #5 clk = ~clk;

    dds_multi_channel #(.N_CH(4), .PHASE_W(16), .ADDR_W(8), .LUT_W(8),
                        .AMP_W(8), .AMP_QI(3), .LUT_FILE("")) dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .sync_i(sync_i),
        .ch_en_i(ch_en_i), .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i),
        .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
        .out_valid_o(out_valid_o), .out_ch_o(out_ch_o), .sine_o(sine_o),
        .cosine_o(cosine_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .overrun_o(overrun_o));

    int tests = 0, fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame timeline view) ----------------
    int m_ftw_sh[4], m_ofs_sh[4], m_as_sh[4], m_ac_sh[4];
    int m_ftw[4], m_ofs[4], m_as[4], m_ac[4], m_acc[4];
    int m_es[4], m_ec[4];
    bit m_act = 0, m_busy_prev = 0;
    int m_edge = 0, m_start = 0;
    int h_s = 0, h_c = 0, h_ch = 0;

    function automatic int rom(input int a);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
        return (v < 0.0) ? -$rtoi(-v + 0.5) : $rtoi(v + 0.5);
    endfunction

    function automatic int sx8(input int v);
        int t;
        t = v & 255;
        return (t >= 128) ? t - 256 : t;
    endfunction

    // One clock: model consumes the inputs seen at the edge, then every output is checked.
    task automatic cyc();
        int k, base, p, a;
        bit e_vld, e_done, e_busy, e_ovr;
        @(posedge clk);
        m_edge++;
        e_ovr = 0;
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                m_ftw_sh[c] = 0; m_ofs_sh[c] = 0; m_as_sh[c] = 0; m_ac_sh[c] = 0;
                m_ftw[c] = 0; m_ofs[c] = 0; m_as[c] = 0; m_ac[c] = 0; m_acc[c] = 0;
            end
            m_act = 0; h_s = 0; h_c = 0; h_ch = 0;
        end else begin
            if (cfg_we_i && int'(cfg_ch_i) < N_CH) begin
                case (int'(cfg_sel_i))
                    0: m_ftw_sh[cfg_ch_i] = int'(cfg_data_i);
                    1: m_ofs_sh[cfg_ch_i] = int'(cfg_data_i);
                    2: m_as_sh[cfg_ch_i]  = int'(cfg_data_i) & 255;
                    default: m_ac_sh[cfg_ch_i] = int'(cfg_data_i) & 255;
                endcase
            end
            if (tick_i && m_busy_prev) e_ovr = 1;
            else if (tick_i) begin
                m_act = 1; m_start = m_edge;
                for (int c = 0; c < 4; c++) begin
                    m_ftw[c] = m_ftw_sh[c]; m_ofs[c] = m_ofs_sh[c];
                    m_as[c] = m_as_sh[c]; m_ac[c] = m_ac_sh[c];
                    base = sync_i ? 0 : m_acc[c];
                    p = (base + m_ofs[c]) & 16'hFFFF;
                    a = p >> 8;
                    if (ch_en_i[c]) begin
                        m_es[c] = sx8(m_as[c]) * rom(a);
                        m_ec[c] = sx8(m_ac[c]) * rom((a + 64) % 256);
                        m_acc[c] = (base + m_ftw[c]) & 16'hFFFF;
                    end else begin
                        m_es[c] = 0; m_ec[c] = 0;
                    end
                end
            end
        end
        e_vld = 0; e_done = 0; e_busy = 0;
        if (m_act) begin
            k = m_edge - m_start;
            if (k <= N_CH + 2) e_busy = 1;
            else m_act = 0;
            if (k >= 3 && k <= N_CH + 2) begin
                e_vld = 1; h_ch = k - 3; h_s = m_es[k-3]; h_c = m_ec[k-3];
            end
            e_done = (k == N_CH + 2);
        end
        m_busy_prev = e_busy;
        #1;
        chk("out_valid", int'(out_valid_o), int'(e_vld));
        chk("busy", int'(busy_o), int'(e_busy));
        chk("frame_done", int'(frame_done_o), int'(e_done));
        chk("overrun", int'(overrun_o), int'(e_ovr));
        chk("out_ch", int'(out_ch_o), h_ch);
        chk("sine", int'(sine_o), h_s);
        chk("cosine", int'(cosine_o), h_c);
    endtask

    task automatic cfg(input int ch, input int sel, input int data);
        cfg_we_i = 1; cfg_ch_i = 2'(ch); cfg_sel_i = 2'(sel); cfg_data_i = 16'(data);
        cyc();
        cfg_we_i = 0;
    endtask

    typedef struct {
        logic [3:0]         en;
        bit                 sync;
        bit                 wt;   // ch1 PHASE_OFS=4000h written with the tick
        logic signed [15:0] s0, c0, s1, c1;
    } vec_t;

    initial begin
        vec_t tbl[7];
        bit got0, got1;
        logic signed [15:0] gs0, gc0, gs1, gc1;

        tbl[0] = '{4'b0001, 1'b0, 1'b0, 16'h0000, 16'h0FE0, 16'h0000, 16'h0000};
        tbl[1] = '{4'b0001, 1'b0, 1'b0, 16'h0FE0, 16'h0000, 16'h0000, 16'h0000};
        tbl[2] = '{4'b0001, 1'b0, 1'b0, 16'h0000, 16'hF020, 16'h0000, 16'h0000};
        tbl[3] = '{4'b0011, 1'b0, 1'b1, 16'hF020, 16'h0000, 16'h0FE0, 16'h0000};
        tbl[4] = '{4'b0011, 1'b1, 1'b0, 16'h0000, 16'h0FE0, 16'h0FE0, 16'h0000};
        tbl[5] = '{4'b0001, 1'b0, 1'b0, 16'h0FE0, 16'h0000, 16'h0000, 16'h0000};
        tbl[6] = '{4'b0011, 1'b0, 1'b0, 16'h0000, 16'hF020, 16'h0000, 16'hF020};

        // reset, then idle
        rst = 0;
        repeat (3) cyc();
        rst = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle valid", int'(out_valid_o), 0);
            chk("idle sine", int'(sine_o), 0);
        end

        cfg(0, 0, 16384); cfg(0, 2, 8'h20); cfg(0, 3, 8'h20);
        cfg(1, 0, 16'h4000); cfg(1, 2, 8'h20); cfg(1, 3, 8'h20);

        // directed vector table
        for (int i = 0; i < 7; i++) begin
            ch_en_i = tbl[i].en; sync_i = tbl[i].sync; tick_i = 1;
            if (tbl[i].wt) begin
                cfg_we_i = 1; cfg_ch_i = 2'd1; cfg_sel_i = 2'd1; cfg_data_i = 16'h4000;
            end
            cyc();
            tick_i = 0; sync_i = 0; cfg_we_i = 0;
            got0 = 0; got1 = 0; gs0 = 0; gc0 = 0; gs1 = 0; gc1 = 0;
            for (int k = 0; k < 12; k++) begin
                cyc();
                if (out_valid_o && out_ch_o == 2'd0) begin got0 = 1; gs0 = sine_o; gc0 = cosine_o; end
                if (out_valid_o && out_ch_o == 2'd1) begin got1 = 1; gs1 = sine_o; gc1 = cosine_o; end
            end
            chk($sformatf("row%0d ch0 seen", i), int'(got0), 1);
            chk($sformatf("row%0d ch1 seen", i), int'(got1), 1);
            chk($sformatf("row%0d ch0 sine", i), int'(gs0), int'(tbl[i].s0));
            chk($sformatf("row%0d ch0 cos", i), int'(gc0), int'(tbl[i].c0));
            chk($sformatf("row%0d ch1 sine", i), int'(gs1), int'(tbl[i].s1));
            chk($sformatf("row%0d ch1 cos", i), int'(gc1), int'(tbl[i].c1));
        end

        // frame timing with an overrun tick two edges in
        ch_en_i = 4'b1111; tick_i = 1;
        cyc();
        tick_i = 0;
        chk("timing busy k0", int'(busy_o), 1);
        for (int k = 1; k <= 8; k++) begin
            tick_i = (k == 2);
            cyc();
            chk($sformatf("timing valid k%0d", k), int'(out_valid_o), int'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk($sformatf("timing ch k%0d", k), int'(out_ch_o), k - 3);
            chk($sformatf("timing done k%0d", k), int'(frame_done_o), int'(k == 6));
            chk($sformatf("timing busy k%0d", k), int'(busy_o), int'(k <= 6));
            chk($sformatf("timing overrun k%0d", k), int'(overrun_o), int'(k == 2));
        end
        tick_i = 0;

        // mid-frame reset
        ch_en_i = 4'b0001; tick_i = 1;
        cyc();
        tick_i = 0;
        for (int k = 1; k <= 8; k++) begin
            rst = (k == 4) ? 1'b0 : 1'b1;
            cyc();
            if (k >= 4) chk($sformatf("midrst valid k%0d", k), int'(out_valid_o), 0);
        end
        rst = 1;
        cfg(0, 0, 16384); cfg(0, 2, 8'h20); cfg(0, 3, 8'h20);
        tick_i = 1;
        cyc();
        tick_i = 0;
        got0 = 0; gs0 = 0; gc0 = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (out_valid_o && out_ch_o == 2'd0) begin got0 = 1; gs0 = sine_o; gc0 = cosine_o; end
        end
        chk("postrst ch0 seen", int'(got0), 1);
        chk("postrst ch0 sine", int'(gs0), 0);
        chk("postrst ch0 cos", int'(gc0), 4064);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 399) != 0);
            tick_i     = ($urandom_range(0, 3) == 0);
            sync_i     = ($urandom_range(0, 7) == 0);
            ch_en_i    = 4'($urandom);
            cfg_we_i   = ($urandom_range(0, 2) == 0);
            cfg_ch_i   = 2'($urandom);
            cfg_sel_i  = 2'($urandom);
            cfg_data_i = 16'($urandom);
            cyc();
        end
        rst = 1; tick_i = 0; sync_i = 0; cfg_we_i = 0;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
